chip_dispense_seq: RTL and testbench



---
 rtl/chip_dispense_seq_pkg.sv | 18 +
 rtl/chip_dispense_seq_if.sv | 27 ++
 rtl/chip_dispense_seq_ms_timer.sv | 38 +++
 rtl/chip_dispense_seq.sv | 119 +++++++++++
 tb/tb_chip_dispense_seq.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/chip_dispense_seq_pkg.sv
// Shared types and constants for the chip dispense sequencer and the servo pulse generator.
package chip_dispense_seq_pkg;

  localparam int unsigned SERVO_POS_W = 10;
  localparam int unsigned MS_CNT_W    = 16;

  localparam logic [SERVO_POS_W-1:0] HOME_POS_DEF = 10'd256;
  localparam logic [SERVO_POS_W-1:0] DISP_POS_DEF = 10'd512;

  typedef enum logic [2:0] {
    StIdle,
    StToDisp,
    StDwell,
    StToHome,
    StDone
  } state_e;

endpackage

// File: rtl/chip_dispense_seq_if.sv
// Request handshake plus status/servo outputs of the dispense sequencer.
interface chip_dispense_seq_if #(
  parameter int unsigned CNT_W = 4
);
  import chip_dispense_seq_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [CNT_W-1:0]       req_count;
  logic                   abort;
  logic [SERVO_POS_W-1:0] servo_pos;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic [CNT_W-1:0]       chips_done;

  modport master (
    output req_valid, req_count, abort,
    input  req_ready, servo_pos, busy, done, aborted, chips_done
  );

  modport slave (
    input  req_valid, req_count, abort,
    output req_ready, servo_pos, busy, done, aborted, chips_done
  );

endinterface

// File: rtl/chip_dispense_seq_ms_timer.sv
// Millisecond timer: expires exactly i_target_ms*DIV cycles after the last clear.
module chip_dispense_seq_ms_timer
  import chip_dispense_seq_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic [MS_CNT_W-1:0] i_target_ms,
  output logic                o_expire
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0]    r_pre;
  logic [MS_CNT_W-1:0] r_ms;
  logic                w_tick;

  assign w_tick   = (r_pre == PRE_W'(DIV - 1));
  assign o_expire = w_tick && (r_ms == (i_target_ms - MS_CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (i_clear) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_ms  <= r_ms + MS_CNT_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/chip_dispense_seq.sv
// Dispense sequencer: swings the servo HOME->DISPENSE->HOME once per requested chip.
module chip_dispense_seq
  import chip_dispense_seq_pkg::*;
#(
  parameter int unsigned             CLK_HZ   = 50000000,
  parameter logic [SERVO_POS_W-1:0]  HOME_POS = HOME_POS_DEF,
  parameter logic [SERVO_POS_W-1:0]  DISP_POS = DISP_POS_DEF,
  parameter int unsigned             MOVE_MS  = 300,
  parameter int unsigned             DWELL_MS = 200,
  parameter int unsigned             CNT_W    = 4
) (
  input logic                clk,
  input logic                rst_n,
  chip_dispense_seq_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / 1000;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [CNT_W-1:0]       r_remaining;
  logic [CNT_W-1:0]       r_chips_done;
  logic                   r_aborted;
  logic [SERVO_POS_W-1:0] r_servo_pos;
  logic                   w_xfer;
  logic                   w_expire;
  logic                   w_clear;
  logic                   w_abort_act;
  logic [MS_CNT_W-1:0]    w_target_ms;
  logic                   w_req_ready;
  logic                   w_busy;
  logic                   w_done;

  assign w_xfer      = bus.req_valid && (r_state == StIdle);
  assign w_abort_act = bus.abort && (r_state inside {StToDisp, StDwell, StToHome});
  // Any state change restarts the ms timer so every state starts from a clean count.
  assign w_clear     = (w_state_next != r_state);

  chip_dispense_seq_ms_timer #(
    .DIV (DIV)
  ) u_ms_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_target_ms (w_target_ms),
    .o_expire    (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_state_next = (bus.req_count == '0) ? StDone : StToDisp;
        end
      end
      StToDisp: begin
        if (bus.abort)        w_state_next = StToHome;
        else if (w_expire)    w_state_next = StDwell;
      end
      StDwell: begin
        if (bus.abort || w_expire) w_state_next = StToHome;
      end
      StToHome: begin
        if (w_expire) begin
          w_state_next = ((r_remaining == '0) || r_aborted || bus.abort) ? StDone : StToDisp;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_req_ready = (r_state == StIdle);
    w_busy      = (r_state != StIdle);
    w_done      = (r_state == StDone);
    w_target_ms = (r_state == StDwell) ? MS_CNT_W'(DWELL_MS) : MS_CNT_W'(MOVE_MS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining  <= '0;
      r_chips_done <= '0;
      r_aborted    <= 1'b0;
      r_servo_pos  <= HOME_POS;
    end else begin
      r_servo_pos <= (w_state_next inside {StToDisp, StDwell}) ? DISP_POS : HOME_POS;
      if (w_xfer) begin
        r_remaining  <= bus.req_count;
        r_chips_done <= '0;
        r_aborted    <= 1'b0;
      end else begin
        if (w_abort_act) r_aborted <= 1'b1;
        // An abort on the final dwell cycle wins: that chip is not counted.
        if ((r_state == StDwell) && w_expire && !bus.abort) begin
          r_chips_done <= r_chips_done + CNT_W'(1);
          r_remaining  <= r_remaining - CNT_W'(1);
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.servo_pos  = r_servo_pos;
  assign bus.aborted    = r_aborted;
  assign bus.chips_done = r_chips_done;

endmodule

// File: tb/tb_chip_dispense_seq.sv
// Self-checking bench: directed and random requests against a timeline model of the sequencer.
module tb_chip_dispense_seq;
  import chip_dispense_seq_pkg::*;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MOVE_MS  = 3;
  localparam int unsigned DWELL_MS = 2;
  localparam int          DIV      = 10;
  localparam int          T_MOVE   = MOVE_MS * DIV;
  localparam int          T_DISP   = (MOVE_MS + DWELL_MS) * DIV;
  localparam int          T_CHIP   = (2 * MOVE_MS + DWELL_MS) * DIV;
  localparam int          POS_H    = 256;
  localparam int          POS_D    = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  chip_dispense_seq_if #(.CNT_W(CNT_W)) bus ();

  chip_dispense_seq #(
    .CLK_HZ   (10000),
    .MOVE_MS  (MOVE_MS),
    .DWELL_MS (DWELL_MS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Timeline model: offsets are cycles after the transfer edge; ab is the cycle abort is high.
  task automatic model(input int count, input int ab,
                       output int done_off, output int chips, output int abt);
    done_off = count * T_CHIP;
    chips    = count;
    abt      = 0;
    if (count > 0 && ab >= 0 && ab < count * T_CHIP) begin
      abt = 1;
      if ((ab % T_CHIP) < T_DISP) begin
        chips    = ab / T_CHIP;
        done_off = ab + 1 + T_MOVE;
      end else begin
        chips    = ab / T_CHIP + 1;
        done_off = (ab / T_CHIP + 1) * T_CHIP;
      end
    end
  endtask

  function automatic int exp_pos(int count, int ab, int done_off, int off);
    bit disp;
    disp = (off < count * T_CHIP) && ((off % T_CHIP) < T_DISP) && (off < done_off);
    if (count > 0 && ab >= 0 && ab < count * T_CHIP && (ab % T_CHIP) < T_DISP && off > ab)
      disp = 1'b0;
    return disp ? POS_D : POS_H;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (bus.req_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_req(input string name, input int count, input int ab,
                         input bit abort_at_xfer, input bit hold_valid);
    int done_off, chips, abt;
    model(count, ab, done_off, chips, abt);
    wait_ready();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_count = CNT_W'(count);
    bus.abort     = abort_at_xfer;
    @(posedge clk);
    #1;
    bus.req_valid = hold_valid;
    bus.req_count = '0;
    for (int off = 0; off <= done_off + 1; off++) begin
      bus.abort = (off == ab);
      @(negedge clk);
      check($sformatf("%s pos@%0d", name, off), 32'(bus.servo_pos),
            32'(exp_pos(count, ab, done_off, off)));
      check($sformatf("%s done@%0d", name, off), 32'(bus.done), 32'(off == done_off));
      check($sformatf("%s busy@%0d", name, off), 32'(bus.busy), 32'(off <= done_off));
      check($sformatf("%s ready@%0d", name, off), 32'(bus.req_ready), 32'(off > done_off));
      if (off == done_off) begin
        check($sformatf("%s chips", name), 32'(bus.chips_done), 32'(chips));
        check($sformatf("%s aborted", name), 32'(bus.aborted), 32'(abt));
      end
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;
    if (hold_valid) begin
      // The held request (count 0) is taken only once the first one has finished.
      bus.req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s held_done", name), 32'(bus.done), 32'd1);
      check($sformatf("%s held_chips", name), 32'(bus.chips_done), 32'd0);
    end else begin
      @(negedge clk);
      check($sformatf("%s idle_busy", name), 32'(bus.busy), 32'd0);
      check($sformatf("%s chips_hold", name), 32'(bus.chips_done), 32'(chips));
    end
  endtask

  task automatic reset_mid();
    wait_ready();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_count = CNT_W'(2);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("mid pos_before", 32'(bus.servo_pos), 32'(POS_D));
    rst_n = 1'b0;
    #1;
    check("mid pos", 32'(bus.servo_pos), 32'(POS_H));
    check("mid busy", 32'(bus.busy), 32'd0);
    check("mid ready", 32'(bus.req_ready), 32'd1);
    check("mid chips", 32'(bus.chips_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, ab;
    bus.req_valid = 1'b0;
    bus.req_count = '0;
    bus.abort     = 1'b0;
    #23;
    check("rst pos", 32'(bus.servo_pos), 32'(POS_H));
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst ready", 32'(bus.req_ready), 32'd1);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst aborted", 32'(bus.aborted), 32'd0);
    check("rst chips", 32'(bus.chips_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("one", 1, -1, 1'b0, 1'b0);
    run_req("three", 3, -1, 1'b0, 1'b1);
    run_req("zero", 0, -1, 1'b0, 1'b0);
    run_req("abort_disp2", 3, 95, 1'b0, 1'b0);
    run_req("abort_idle", 1, -1, 1'b1, 1'b0);
    run_req("abort_home_last", 2, 150, 1'b0, 1'b0);
    run_req("abort_dwell", 2, 40, 1'b0, 1'b0);
    reset_mid();

    for (int i = 0; i < 8; i++) begin
      cnt = int'($urandom_range(0, 4));
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, cnt * T_CHIP + 3)) : -1;
      run_req($sformatf("rnd%0d", i), cnt, ab, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
